// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - requester/consumer bundle for the 8-lane round-robin arbiter (lock input under ARB_LOCK_EN)
interface mux8_rr_arbiter_if #(
    parameter int DW = 4
);
    logic [7:0]      req;
    logic [8*DW-1:0] din;
    logic [7:0]      gnt;
    logic [2:0]      sl;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif

    modport master (
`ifdef ARB_LOCK_EN
        output lock,
`endif
        output req, din, out_ready,
        input  gnt, sl, out_data, out_valid, busy
    );

    modport slave (
`ifdef ARB_LOCK_EN
        input  lock,
`endif
        input  req, din, out_ready,
        output gnt, sl, out_data, out_valid, busy
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter/sequencer driving the 8:1 lane mux select
// Optional ARB_LOCK_EN: lock input suppresses the MAX_HOLD forced release.
module mux8_rr_arbiter #(
    parameter int DW       = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux8_rr_arbiter_if.slave        bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST = 4'(MAX_HOLD - 1);

    state_t     state_q;
    logic [7:0] gnt_q;
    logic [2:0] sl_q;
    logic [2:0] ptr_q;
    logic [3:0] beat_cnt_q;
    logic       busy_q;

    logic [2:0] pick;
    logic       pick_vld;
    logic [2:0] idx;
    logic       xfer;
    logic       at_limit;
    logic       hold;

    // Scan from the highest offset down so the lowest offset at/after ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr_q + 3'(k);
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign hold = bus.lock;
`else
    assign hold = 1'b0;
`endif

    assign bus.out_valid = busy_q & bus.req[sl_q];
    assign bus.out_data  = bus.din[DW*sl_q +: DW];
    assign bus.gnt       = gnt_q;
    assign bus.sl        = sl_q;
    assign bus.busy      = busy_q;

    assign xfer     = bus.out_valid & bus.out_ready;
    assign at_limit = (beat_cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sl_q       <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q      <= 8'b1 << pick;
                        sl_q       <= pick;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[sl_q] || (xfer && at_limit && !hold)) begin
                        gnt_q   <= '0;
                        ptr_q   <= sl_q + 3'd1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (xfer && !at_limit) begin
                        // Saturates at LAST when a locked transfer hits the limit.
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
